// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer: walks CMD0/CMD8/CMD55+ACMD41/CMD2/CMD3/CMD7
// through an external command engine and reports card type, RCA and status.
module sd_init_seq #(
   parameter int POWERUP_CYCLES   = 2000,
   parameter int ACMD41_MAX_TRIES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        cmd_start,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_expect_resp,
   input  logic        cmd_ready,
   input  logic        cmd_done,
   input  logic [31:0] resp,
   input  logic        resp_timeout,
   input  logic        resp_crc_err,
   output logic        fast_clk_en,
   output logic        init_done,
   output logic        init_err,
   output logic [2:0]  err_code,
   output logic        sd_v2,
   output logic        card_ccs,
   output logic [15:0] rca
);

   localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam int TW = (ACMD41_MAX_TRIES > 1) ? $clog2(ACMD41_MAX_TRIES + 1) : 1;
   localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);
   localparam logic [TW-1:0] TRY_MAX  = TW'(ACMD41_MAX_TRIES);

   typedef enum logic [3:0] {
      S_IDLE, S_POWERUP, S_CMD0, S_CMD8, S_CMD55, S_ACMD41,
      S_CMD2, S_CMD3, S_CMD7, S_DONE, S_ERROR
   } state_t;

   typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

   state_t        state;
   phase_t        phase;
   logic [PW-1:0] pwr_cnt;
   logic [TW-1:0] try_cnt;
   logic [TW-1:0] try_next;
   logic [5:0]    issue_index;
   logic [31:0]   issue_arg;
   logic          to_fail;
   logic          crc_fail;
   logic          resp_unused;

   assign try_next    = try_cnt + TW'(1);
   assign resp_unused = ^resp[15:12];

   // CMD8 timeout means a v1 card and R3 (ACMD41) carries no CRC, so those
   // flags are not failures there; timeout outranks a CRC error.
   assign to_fail  = resp_timeout && !(state inside {S_CMD0, S_CMD8});
   assign crc_fail = resp_crc_err && !resp_timeout && !(state inside {S_CMD0, S_ACMD41});

   always_comb begin
      issue_index = 6'd0;
      issue_arg   = 32'd0;
      case (state)
         S_CMD8: begin
            issue_index = 6'd8;
            issue_arg   = 32'h0000_01AA;
         end
         S_CMD55: begin
            issue_index = 6'd55;
            issue_arg   = {rca, 16'h0000};
         end
         S_ACMD41: begin
            issue_index = 6'd41;
            issue_arg   = 32'h00FF_8000 | {1'b0, sd_v2, 30'd0};
         end
         S_CMD2:  issue_index = 6'd2;
         S_CMD3:  issue_index = 6'd3;
         S_CMD7: begin
            issue_index = 6'd7;
            issue_arg   = {rca, 16'h0000};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         phase           <= PH_ISSUE;
         pwr_cnt         <= '0;
         try_cnt         <= '0;
         cmd_start       <= 1'b0;
         cmd_index       <= 6'd0;
         cmd_arg         <= 32'd0;
         cmd_expect_resp <= 1'b0;
         fast_clk_en     <= 1'b0;
         init_done       <= 1'b0;
         init_err        <= 1'b0;
         err_code        <= 3'd0;
         sd_v2           <= 1'b0;
         card_ccs        <= 1'b0;
         rca             <= 16'd0;
      end else begin
         cmd_start <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state       <= S_POWERUP;
                  phase       <= PH_ISSUE;
                  pwr_cnt     <= '0;
                  try_cnt     <= '0;
                  fast_clk_en <= 1'b0;
                  init_done   <= 1'b0;
                  init_err    <= 1'b0;
                  err_code    <= 3'd0;
                  sd_v2       <= 1'b0;
                  card_ccs    <= 1'b0;
                  rca         <= 16'd0;
               end
            end
            S_POWERUP: begin
               if (pwr_cnt == PWR_LAST) begin
                  state <= S_CMD0;
                  phase <= PH_ISSUE;
               end else begin
                  pwr_cnt <= pwr_cnt + PW'(1);
               end
            end
            default: begin
               if (phase == PH_ISSUE) begin
                  cmd_index       <= issue_index;
                  cmd_arg         <= issue_arg;
                  cmd_expect_resp <= (state != S_CMD0);
                  if (cmd_ready) begin
                     cmd_start <= 1'b1;
                     phase     <= PH_WAIT;
                  end
               end else if (cmd_done) begin
                  phase <= PH_ISSUE;
                  if (to_fail) begin
                     state    <= S_ERROR;
                     init_err <= 1'b1;
                     err_code <= 3'd1;
                  end else if (crc_fail) begin
                     state    <= S_ERROR;
                     init_err <= 1'b1;
                     err_code <= 3'd2;
                  end else begin
                     case (state)
                        S_CMD0: state <= S_CMD8;
                        S_CMD8: begin
                           if (resp_timeout) begin
                              sd_v2 <= 1'b0;
                              state <= S_CMD55;
                           end else if (resp[11:0] == 12'h1AA) begin
                              sd_v2 <= 1'b1;
                              state <= S_CMD55;
                           end else begin
                              state    <= S_ERROR;
                              init_err <= 1'b1;
                              err_code <= 3'd3;
                           end
                        end
                        S_CMD55: state <= S_ACMD41;
                        S_ACMD41: begin
                           if (resp[31]) begin
                              card_ccs <= resp[30];
                              state    <= S_CMD2;
                           end else begin
                              try_cnt <= try_next;
                              if (try_next == TRY_MAX) begin
                                 state    <= S_ERROR;
                                 init_err <= 1'b1;
                                 err_code <= 3'd4;
                              end else begin
                                 state <= S_CMD55;
                              end
                           end
                        end
                        S_CMD2: state <= S_CMD3;
                        S_CMD3: begin
                           rca   <= resp[31:16];
                           state <= S_CMD7;
                        end
                        S_CMD7: begin
                           state       <= S_DONE;
                           init_done   <= 1'b1;
                           fast_clk_en <= 1'b1;
                        end
                        default: state <= S_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_init_seq.sv
// Directed bench for sd_init_seq: a table of expected commands and card
// responses per scenario, plus hand-written reset/restart sequences.
module tb_sd_init_seq;

   localparam int PWR  = 20;
   localparam int MAXT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_expect_resp;
   logic        cmd_ready;
   logic        cmd_done;
   logic [31:0] resp;
   logic        resp_timeout;
   logic        resp_crc_err;
   logic        fast_clk_en;
   logic        init_done;
   logic        init_err;
   logic [2:0]  err_code;
   logic        sd_v2;
   logic        card_ccs;
   logic [15:0] rca;

   sd_init_seq #(.POWERUP_CYCLES(PWR), .ACMD41_MAX_TRIES(MAXT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
      .cmd_expect_resp(cmd_expect_resp), .cmd_ready(cmd_ready),
      .cmd_done(cmd_done), .resp(resp), .resp_timeout(resp_timeout),
      .resp_crc_err(resp_crc_err), .fast_clk_en(fast_clk_en),
      .init_done(init_done), .init_err(init_err), .err_code(err_code),
      .sd_v2(sd_v2), .card_ccs(card_ccs), .rca(rca)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [31:0] rsp;
      logic        to;
      logic        crc;
   } cmd_rec_t;

   typedef struct {
      int          first;
      int          count;
      logic        done;
      logic        err;
      logic [2:0]  code;
      logic        v2;
      logic        ccs;
      logic [15:0] rca;
   } scen_t;

   cmd_rec_t recs [0:63];
   scen_t    scens [0:7];
   int       nrec = 0;
   int       nscen = 0;
   int       tests_run = 0;
   int       tests_failed = 0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic add_rec(input logic [5:0] idx, input logic [31:0] arg, input logic [31:0] rsp,
                          input logic to, input logic crc);
      recs[nrec] = '{idx, arg, rsp, to, crc};
      nrec++;
   endtask

   task automatic add_scen(input int count, input logic done, input logic err, input logic [2:0] code,
                           input logic v2, input logic ccs, input logic [15:0] r);
      scens[nscen] = '{nrec - count, count, done, err, code, v2, ccs, r};
      nscen++;
   endtask

   task automatic wait_cmd(input int budget, output bit seen);
      int cycles;
      seen = 1'b0;
      cycles = 0;
      while (cycles < budget && !seen) begin
         @(negedge clk);
         cycles++;
         if (cmd_start) seen = 1'b1;
      end
   endtask

   // Engine model: drop ready while busy, answer two cycles later.
   task automatic respond(input int r);
      cmd_ready = 1'b0;
      @(negedge clk);
      check_output($sformatf("rec%0d_start_one_cycle", r), cmd_start, 0);
      repeat (2) @(negedge clk);
      check_output($sformatf("rec%0d_index_held", r), cmd_index, recs[r].idx);
      cmd_done     = 1'b1;
      resp         = recs[r].rsp;
      resp_timeout = recs[r].to;
      resp_crc_err = recs[r].crc;
      @(negedge clk);
      cmd_done     = 1'b0;
      resp         = 32'd0;
      resp_timeout = 1'b0;
      resp_crc_err = 1'b0;
      cmd_ready    = 1'b1;
   endtask

   task automatic apply_stimulus(input int r, input bit already_seen);
      bit seen;
      seen = already_seen;
      if (!seen) wait_cmd(60, seen);
      check_output($sformatf("rec%0d_cmd_issued", r), seen, 1);
      if (seen) begin
         check_output($sformatf("rec%0d_index", r), cmd_index, recs[r].idx);
         check_output($sformatf("rec%0d_arg", r), cmd_arg, recs[r].arg);
         check_output($sformatf("rec%0d_expect_resp", r), cmd_expect_resp, recs[r].idx != 6'd0);
      end
      respond(r);
   endtask

   // Start, confirm state cleared, and measure the cycles until CMD0 issues.
   task automatic start_powerup(output bit seen);
      int cycles;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output("restart_clear", {fast_clk_en, init_done, init_err, err_code, sd_v2, card_ccs, rca}, 0);
      cycles = 1;
      seen = 1'b0;
      while (cycles < PWR + 10 && !seen) begin
         @(negedge clk);
         cycles++;
         if (cmd_start) seen = 1'b1;
      end
      check_output("powerup_cycles", cycles, PWR + 2);
   endtask

   task automatic run_scenario(input int s);
      bit seen;
      bit extra;
      start_powerup(seen);
      apply_stimulus(scens[s].first, seen);
      for (int i = 1; i < scens[s].count; i++) apply_stimulus(scens[s].first + i, 1'b0);
      @(negedge clk);
      check_output($sformatf("s%0d_init_done", s), init_done, scens[s].done);
      check_output($sformatf("s%0d_fast_clk_en", s), fast_clk_en, scens[s].done);
      check_output($sformatf("s%0d_init_err", s), init_err, scens[s].err);
      check_output($sformatf("s%0d_err_code", s), err_code, scens[s].code);
      check_output($sformatf("s%0d_sd_v2", s), sd_v2, scens[s].v2);
      check_output($sformatf("s%0d_card_ccs", s), card_ccs, scens[s].ccs);
      check_output($sformatf("s%0d_rca", s), rca, scens[s].rca);
      extra = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (cmd_start) extra = 1'b1;
      end
      check_output($sformatf("s%0d_no_further_cmd", s), extra, 0);
   endtask

   initial begin
      bit seen;
      bit bad;
      int cycles;

      // v2 high-capacity card, two busy ACMD41 replies
      add_rec(0, 0, 0, 0, 0);
      add_rec(8, 32'h1AA, 32'h1AA, 0, 0);
      add_rec(55, 0, 32'h120, 0, 0);
      add_rec(41, 32'h40FF8000, 32'h00FF8000, 0, 0);
      add_rec(55, 0, 32'h120, 0, 0);
      add_rec(41, 32'h40FF8000, 32'h00FF8000, 0, 0);
      add_rec(55, 0, 32'h120, 0, 0);
      add_rec(41, 32'h40FF8000, 32'hC0FF8000, 0, 0);
      add_rec(2, 0, 32'hDEADBEEF, 0, 0);
      add_rec(3, 0, 32'h12340000, 0, 0);
      add_rec(7, 32'h12340000, 0, 0, 0);
      add_scen(11, 1, 0, 0, 1, 1, 16'h1234);
      // v1 card: CMD0 flags and ACMD41 CRC error must both be ignored
      add_rec(0, 0, 0, 1, 1);
      add_rec(8, 32'h1AA, 0, 1, 0);
      add_rec(55, 0, 32'h120, 0, 0);
      add_rec(41, 32'h00FF8000, 32'h80FF8000, 0, 1);
      add_rec(2, 0, 0, 0, 0);
      add_rec(3, 0, 32'hABCD0000, 0, 0);
      add_rec(7, 32'hABCD0000, 0, 0, 0);
      add_scen(7, 1, 0, 0, 0, 0, 16'hABCD);
      // bad CMD8 echo
      add_rec(0, 0, 0, 0, 0);
      add_rec(8, 32'h1AA, 32'h1AB, 0, 0);
      add_scen(2, 0, 1, 3, 0, 0, 0);
      // ACMD41 never ready
      add_rec(0, 0, 0, 0, 0);
      add_rec(8, 32'h1AA, 32'h1AA, 0, 0);
      for (int i = 0; i < MAXT; i++) begin
         add_rec(55, 0, 32'h120, 0, 0);
         add_rec(41, 32'h40FF8000, 32'h00FF8000, 0, 0);
      end
      add_scen(2 + 2 * MAXT, 0, 1, 4, 1, 0, 0);
      // CMD2 timeout together with CRC error: timeout wins
      add_rec(0, 0, 0, 0, 0);
      add_rec(8, 32'h1AA, 32'h1AA, 0, 0);
      add_rec(55, 0, 32'h120, 0, 0);
      add_rec(41, 32'h40FF8000, 32'h80FF8000, 0, 0);
      add_rec(2, 0, 0, 1, 1);
      add_scen(5, 0, 1, 1, 1, 0, 0);
      // CMD3 CRC error: rca must not be captured
      add_rec(0, 0, 0, 0, 0);
      add_rec(8, 32'h1AA, 0, 1, 0);
      add_rec(55, 0, 32'h120, 0, 0);
      add_rec(41, 32'h00FF8000, 32'hC0FF8000, 0, 0);
      add_rec(2, 0, 0, 0, 0);
      add_rec(3, 0, 32'h55550000, 0, 1);
      add_scen(6, 0, 1, 2, 0, 1, 0);

      rst = 1'b0;
      start = 1'b0;
      cmd_ready = 1'b1;
      cmd_done = 1'b0;
      resp = 32'd0;
      resp_timeout = 1'b0;
      resp_crc_err = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_outputs", {cmd_start, cmd_index, cmd_expect_resp, fast_clk_en, init_done,
                                      init_err, err_code, sd_v2, card_ccs}, 0);
      check_output("reset_arg", cmd_arg, 0);
      check_output("reset_rca", rca, 0);
      rst = 1'b1;
      @(negedge clk);
      cmd_done = 1'b1;
      resp = 32'h1AA;
      @(negedge clk);
      cmd_done = 1'b0;
      resp = 32'd0;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (cmd_start || init_done || init_err) bad = 1'b1;
      end
      check_output("idle_after_reset", bad, 0);

      for (int s = 0; s < nscen; s++) run_scenario(s);

      // Reset while ACMD41 is outstanding, then a stale completion arrives.
      start_powerup(seen);
      apply_stimulus(0, seen);
      apply_stimulus(1, 1'b0);
      apply_stimulus(2, 1'b0);
      wait_cmd(60, seen);
      check_output("acmd41_issued", {seen, cmd_index}, {1'b1, 6'd41});
      cmd_ready = 1'b0;
      @(negedge clk);
      check_output("sd_v2_before_reset", sd_v2, 1);
      #2 rst = 1'b0;
      #1;
      check_output("async_reset_outputs", {cmd_start, cmd_index, cmd_expect_resp, fast_clk_en, init_done,
                                           init_err, err_code, sd_v2, card_ccs}, 0);
      check_output("async_reset_arg", cmd_arg, 0);
      check_output("async_reset_rca", rca, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      cmd_done = 1'b1;
      resp = 32'hC0FF8000;
      @(negedge clk);
      cmd_done = 1'b0;
      resp = 32'd0;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (cmd_start || init_done || card_ccs) bad = 1'b1;
      end
      check_output("late_done_ignored", bad, 0);

      // Restart with the engine busy: CMD0 must wait for cmd_ready.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 1;
      bad = 1'b0;
      while (cycles < PWR + 5) begin
         @(negedge clk);
         cycles++;
         if (cmd_start) bad = 1'b1;
      end
      check_output("no_start_while_busy", bad, 0);
      cmd_ready = 1'b1;
      @(negedge clk);
      check_output("cmd0_after_ready", {cmd_start, cmd_index}, {1'b1, 6'd0});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 2000, clk cycles waited before CMD0.
REQ-002 SHALL have parameter ACMD41_MAX_TRIES, default 1000, CMD55/ACMD41 pairs allowed before failure.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin initialisation; sampled in IDLE, DONE, ERROR.
REQ-006 SHALL have ports cmd_start output 1 (one-cycle issue pulse), cmd_index output 6, cmd_arg output 32, cmd_expect_resp output 1 (0 for CMD0 only).
REQ-007 SHALL have port cmd_ready  input  1  command engine idle and able to accept cmd_start.
REQ-008 SHALL have ports cmd_done input 1 (one-cycle completion pulse), resp input 32 (response bits [39:8]), resp_timeout input 1, resp_crc_err input 1; resp/flags valid only with cmd_done.
REQ-009 SHALL have outputs fast_clk_en 1, init_done 1, init_err 1, err_code 3, sd_v2 1, card_ccs 1, rca 16.

Function
REQ-010 States: IDLE, POWERUP, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, DONE, ERROR; each CMDx state has ISSUE and WAIT phases.
REQ-011 IDLE->POWERUP on start=1; POWERUP counts POWERUP_CYCLES cycles (cmd_start held 0), then ->CMD0.
REQ-012 ISSUE phase: drive cmd_index/cmd_arg; pulse cmd_start exactly one cycle on first cycle cmd_ready=1; cmd_index/cmd_arg held stable until cmd_done.
REQ-013 WAIT phase: no further cmd_start; advance only on cmd_done=1; no timeout counter inside this block.
REQ-014 CMD0: index 0, arg 0, cmd_expect_resp=0; resp/flags ignored; ->CMD8.
REQ-015 CMD8: index 8, arg 0x000001AA; timeout -> sd_v2=0, ->CMD55; resp[11:0]==0x1AA -> sd_v2=1, ->CMD55; other resp -> ERROR code 3.
REQ-016 CMD55: index 55, arg {rca,16'h0} (rca=0 during init); ->ACMD41.
REQ-017 ACMD41: index 41, arg = 0x00FF8000 | (sd_v2<<30); resp[31]=1 -> card_ccs=resp[30], ->CMD2; resp[31]=0 -> try counter +1, ->CMD55, or ERROR code 4 when counter reaches ACMD41_MAX_TRIES.
REQ-018 ACMD41 response CRC errors SHALL be ignored (R3 carries no CRC); all other commands check it.
REQ-019 CMD2: index 2, arg 0; ->CMD3. CMD3: index 3, arg 0; rca=resp[31:16]; ->CMD7.
REQ-020 CMD7: index 7, arg {rca,16'h0}; ->DONE.
REQ-021 Any cmd_done with resp_timeout=1 (except CMD0, CMD8) -> ERROR code 1; with resp_crc_err=1 (except CMD0, ACMD41) -> ERROR code 2; timeout has priority over CRC.
REQ-022 DONE: init_done=1, fast_clk_en=1; ERROR: init_err=1, err_code held, fast_clk_en=0.
REQ-023 start=1 in DONE/ERROR SHALL clear init_done, init_err, err_code, sd_v2, card_ccs, rca, try counter and -> POWERUP.
REQ-024 start ignored in all states other than IDLE, DONE, ERROR.
REQ-025 cmd_done arriving in an ISSUE phase or in IDLE/POWERUP/DONE/ERROR SHALL be ignored.
REQ-026 Try counter SHALL be wide enough for ACMD41_MAX_TRIES without wrap; it resets only at POWERUP entry.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, cmd_start=0, cmd_index=0, cmd_arg=0, cmd_expect_resp=0, fast_clk_en=0, init_done=0, init_err=0, err_code=0, sd_v2=0, card_ccs=0, rca=0, counters=0, including mid-command.
REQ-028 After rst release SHALL remain IDLE until start=1; pending engine cmd_done SHALL be ignored.

Verification
REQ-029 v2 card: CMD8 resp 0x1AA, ACMD41 resp 0x00FF8000 twice then 0xC0FF8000, CMD3 resp 0x12340000 -> sequence 0,8,55,41,55,41,55,41,2,3,7; CMD7 arg 0x12340000; init_done=1, sd_v2=1, card_ccs=1, rca=0x1234.
REQ-030 v1 card: CMD8 timeout -> sd_v2=0, ACMD41 arg 0x00FF8000; ready resp 0x80FF8000 -> card_ccs=0, DONE.
REQ-031 CMD8 resp 0x000001AB -> ERROR, err_code=3, no further cmd_start.
REQ-032 ACMD41_MAX_TRIES=3, ACMD41 always busy -> exactly 3 ACMD41 issued, err_code=4; CMD2 timeout -> err_code=1; CMD3 CRC error -> err_code=2.
REQ-033 rst=0 during ACMD41 WAIT -> all outputs at REQ-027 values same cycle; late cmd_done ignored; start=1 restarts with POWERUP_CYCLES wait, cmd_start held low before CMD0, and cmd_ready=0 delays cmd_start until it rises.
